// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into SEG-bit
// segments, one segment resolved per stage, with the carry registered between
// stages. The last stage's registers are the output registers.
//
// Handshake: an operand transfer happens on a rising edge where
// in_valid & in_ready; a result transfer happens where out_valid & out_ready.
// in_ready = advance = !out_valid | out_ready. When advance is 0 every
// register in the pipe (outputs included) holds its value.
module pipelined_add_sub #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SEG_SAFE = (SEG > 0) ? SEG : 1;
   localparam int STAGES   = (WIDTH / SEG_SAFE > 0) ? (WIDTH / SEG_SAFE) : 1;

   // Refuse to build with a segment size that does not tile the operand.
   generate
      if ((SEG < 1) || (WIDTH < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_params
         $error("pipelined_add_sub: WIDTH must be a positive multiple of SEG (SEG >= 1)");
      end
   endgenerate

   // Per-stage registers: valid, operand A, B' (B or ~B), partial sum, carry.
   logic             vld_q [STAGES];
   logic             vld_d [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] a_d   [STAGES];
   logic [WIDTH-1:0] bp_q  [STAGES];
   logic [WIDTH-1:0] bp_d  [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic [WIDTH-1:0] s_d   [STAGES];
   logic             c_q   [STAGES];
   logic             c_d   [STAGES];
   logic             ovf_q;
   logic             ovf_d;
   logic             zero_q;
   logic             zero_d;

   // Values presented to each stage (port side for stage 0, previous rank otherwise).
   logic             st_v  [STAGES];
   logic [WIDTH-1:0] st_a  [STAGES];
   logic [WIDTH-1:0] st_b  [STAGES];
   logic [WIDTH-1:0] st_s  [STAGES];
   logic             st_c  [STAGES];

   logic             advance;
   logic [SEG_SAFE:0]   seg_r;
   logic [WIDTH-1:0] s_nx;

   assign advance   = !vld_q[STAGES-1] | out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   // Route each stage's inputs: ports into stage 0, rank k-1 into stage k.
   always_comb begin
      st_v[0] = in_valid;
      st_a[0] = a;
      st_b[0] = sub ? ~b : b;
      st_s[0] = '0;
      st_c[0] = sub ? 1'b1 : cin;
      for (int k = 1; k < STAGES; k++) begin
         st_v[k] = vld_q[k-1];
         st_a[k] = a_q[k-1];
         st_b[k] = bp_q[k-1];
         st_s[k] = s_q[k-1];
         st_c[k] = c_q[k-1];
      end
   end

   // Resolve one segment per stage; the whole pipe moves only when advance=1.
   always_comb begin
      ovf_d  = ovf_q;
      zero_d = zero_q;
      seg_r  = '0;
      s_nx   = '0;
      for (int k = 0; k < STAGES; k++) begin
         vld_d[k] = vld_q[k];
         a_d[k]   = a_q[k];
         bp_d[k]  = bp_q[k];
         s_d[k]   = s_q[k];
         c_d[k]   = c_q[k];
      end
      if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            seg_r = {1'b0, st_a[k][k*SEG_SAFE +: SEG_SAFE]}
                  + {1'b0, st_b[k][k*SEG_SAFE +: SEG_SAFE]}
                  + {{SEG_SAFE{1'b0}}, st_c[k]};
            s_nx  = st_s[k];
            s_nx[k*SEG_SAFE +: SEG_SAFE] = seg_r[SEG_SAFE-1:0];
            vld_d[k] = st_v[k];
            // The output rank keeps its last result when a bubble arrives.
            if ((k < STAGES-1) || st_v[k]) begin
               a_d[k]  = st_a[k];
               bp_d[k] = st_b[k];
               s_d[k]  = s_nx;
               c_d[k]  = seg_r[SEG_SAFE];
            end
            if ((k == STAGES-1) && st_v[k]) begin
               ovf_d  = (st_a[k][WIDTH-1] == st_b[k][WIDTH-1]) &&
                        (s_nx[WIDTH-1] != st_a[k][WIDTH-1]);
               zero_d = (s_nx == '0);
            end
         end
      end
   end

   // Stage registers with synchronous reset that clears every in-flight op.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= 1'b0;
            a_q[k]   <= '0;
            bp_q[k]  <= '0;
            s_q[k]   <= '0;
            c_q[k]   <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= vld_d[k];
            a_q[k]   <= a_d[k];
            bp_q[k]  <= bp_d[k];
            s_q[k]   <= s_d[k];
            c_q[k]   <= c_d[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

endmodule
